// File: rtl/usb_ulpi_pkg.sv
// Shared ULPI transmit definitions: FSM states, PID nibbles, TX CMD prefix and USB CRC16 constants.
package usb_ulpi_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CRC_W  = 16;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    DATA,
    CRC_LO,
    CRC_HI,
    STOP,
    ABORT,
    FLUSH
  } tx_state_e;

  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_DATA2 = 4'h7;
  localparam logic [3:0] PID_MDATA = 4'hF;

  localparam logic [3:0] TXCMD_PFX = 4'b0100;

  localparam logic [CRC_W-1:0] CRC16_POLY = 16'hA001;
  localparam logic [CRC_W-1:0] CRC16_INIT = 16'hFFFF;

  // Data PIDs carry a CRC16-protected payload
  function automatic logic is_data_pid(input logic [3:0] pid_lo);
    return (pid_lo == PID_DATA0) || (pid_lo == PID_DATA1) ||
           (pid_lo == PID_DATA2) || (pid_lo == PID_MDATA);
  endfunction

  // One byte of reflected CRC16, LSB first as transmitted on the wire
  function automatic logic [CRC_W-1:0] crc16_byte(input logic [CRC_W-1:0] crc_in,
                                                  input logic [BYTE_W-1:0] b);
    logic [CRC_W-1:0] c;
    c = crc_in ^ CRC_W'(b);
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC16_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/usb_crc16.sv
// Byte-wide USB CRC16 accumulator (uncomplemented residue); built only with ULPI_TX_CRC16_EN.
`ifdef ULPI_TX_CRC16_EN
module usb_crc16
  import usb_ulpi_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [BYTE_W-1:0] data,
  output logic [CRC_W-1:0]  crc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= CRC16_INIT;
    end else if (clr) begin
      crc <= CRC16_INIT;
    end else if (en) begin
      crc <= crc16_byte(crc, data);
    end
  end

endmodule
`endif

// File: rtl/ulpi_tx_sender.sv
// Link-side ULPI transmit FSM: TX CMD, nxt-paced payload, stp termination, dir preemption.
// Optional hardware CRC16 appending for data PIDs with ULPI_TX_CRC16_EN.
module ulpi_tx_sender
  import usb_ulpi_pkg::*;
#(
  parameter logic [3:0]        TXCMD_PREFIX = TXCMD_PFX,
  parameter logic [BYTE_W-1:0] ABORT_BYTE   = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] tx_data,
  input  logic              tx_valid,
  input  logic              tx_last,
  output logic              tx_ready,
  input  logic              dir,
  input  logic              nxt,
  output logic [BYTE_W-1:0] ulpi_data_out,
  output logic              ulpi_oe,
  output logic              stp,
  output logic              tx_done,
  output logic              tx_abort,
  output logic              busy
);

  tx_state_e         state_q, state_d;
  logic              ta_q;
  logic [BYTE_W-1:0] data_c;

`ifdef ULPI_TX_CRC16_EN
  logic             crc_clr, crc_en, crc_pid_q;
  logic [CRC_W-1:0] crc_res;

  usb_crc16 u_crc (
    .clk  (clk),
    .rst  (rst),
    .clr  (crc_clr),
    .en   (crc_en),
    .data (tx_data),
    .crc  (crc_res)
  );

  // Latched at PID pop: decides whether CRC bytes follow the payload
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_pid_q <= 1'b0;
    end else if (crc_clr) begin
      crc_pid_q <= is_data_pid(tx_data[3:0]);
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ta_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      ta_q    <= dir;
    end
  end

  // Release on dir rise, one turnaround cycle after dir falls
  assign ulpi_oe       = !dir && !ta_q;
  assign ulpi_data_out = ulpi_oe ? data_c : '0;
  assign busy          = (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    data_c   = '0;
    stp      = 1'b0;
    tx_ready = 1'b0;
    tx_done  = 1'b0;
    tx_abort = 1'b0;
`ifdef ULPI_TX_CRC16_EN
    crc_clr  = 1'b0;
    crc_en   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (tx_valid && ulpi_oe) begin
          data_c  = {TXCMD_PREFIX, tx_data[3:0]};
          state_d = CMD;
        end
      end
      CMD: begin
        data_c = {TXCMD_PREFIX, tx_data[3:0]};
        if (dir) begin
          state_d = IDLE;
        end else if (nxt) begin
          tx_ready = 1'b1;
          state_d  = tx_last ? STOP : DATA;
`ifdef ULPI_TX_CRC16_EN
          crc_clr = 1'b1;
          if (tx_last && is_data_pid(tx_data[3:0])) state_d = CRC_LO;
`endif
        end
      end
      DATA: begin
        data_c = tx_data;
        if (dir) begin
          tx_abort = 1'b1;
          state_d  = FLUSH;
        end else if (nxt) begin
          if (tx_valid) begin
            tx_ready = 1'b1;
`ifdef ULPI_TX_CRC16_EN
            crc_en = 1'b1;
            if (tx_last) state_d = crc_pid_q ? CRC_LO : STOP;
`else
            if (tx_last) state_d = STOP;
`endif
          end else begin
            state_d = ABORT;
          end
        end
      end
`ifdef ULPI_TX_CRC16_EN
      // Upstream is already drained here, so a preempt goes straight to IDLE
      CRC_LO: begin
        data_c = ~crc_res[7:0];
        if (dir) begin
          tx_abort = 1'b1;
          state_d  = IDLE;
        end else if (nxt) begin
          state_d = CRC_HI;
        end
      end
      CRC_HI: begin
        data_c = ~crc_res[15:8];
        if (dir) begin
          tx_abort = 1'b1;
          state_d  = IDLE;
        end else if (nxt) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        stp     = 1'b1;
        tx_done = 1'b1;
        state_d = IDLE;
      end
      ABORT: begin
        stp      = 1'b1;
        data_c   = ABORT_BYTE;
        tx_abort = 1'b1;
        state_d  = FLUSH;
      end
      FLUSH: begin
        tx_ready = tx_valid;
        if (tx_valid && tx_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ulpi_tx_sender.sv
// Bench for ulpi_tx_sender: per-cycle vector table through an expectation queue, plus a mid-packet dir sequence.
module tb_ulpi_tx_sender;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic       tx_ready;
  logic       dir = 1'b0;
  logic       nxt = 1'b0;
  logic [7:0] ulpi_data_out;
  logic       ulpi_oe;
  logic       stp;
  logic       tx_done;
  logic       tx_abort;
  logic       busy;

  always #5 clk = ~clk;

  ulpi_tx_sender dut (
    .clk           (clk),
    .rst           (rst),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_last       (tx_last),
    .tx_ready      (tx_ready),
    .dir           (dir),
    .nxt           (nxt),
    .ulpi_data_out (ulpi_data_out),
    .ulpi_oe       (ulpi_oe),
    .stp           (stp),
    .tx_done       (tx_done),
    .tx_abort      (tx_abort),
    .busy          (busy)
  );

  typedef struct {
    string      name;
    logic       rst, dir, nxt, val, last;
    logic [7:0] d;
    logic [7:0] e_data;
    logic       e_oe, e_stp, e_rdy, e_done, e_abt, e_busy;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic vec_t mk(input string nm, input logic r, input logic dr, input logic nx,
                              input logic v, input logic l, input logic [7:0] d,
                              input logic [7:0] ed, input logic eoe, input logic estp,
                              input logic erdy, input logic edone, input logic eabt,
                              input logic ebusy);
    vec_t t;
    t.name = nm; t.rst = r; t.dir = dr; t.nxt = nx; t.val = v; t.last = l; t.d = d;
    t.e_data = ed; t.e_oe = eoe; t.e_stp = estp; t.e_rdy = erdy;
    t.e_done = edone; t.e_abt = eabt; t.e_busy = ebusy;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, got, want);
  endtask

`ifdef ULPI_TX_CRC16_EN
  function automatic logic [15:0] usb_crc2(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] c;
    logic [7:0]  cur;
    c = 16'hFFFF;
    for (int k = 0; k < 2; k++) begin
      cur = (k == 0) ? a : b;
      c = c ^ {8'h00, cur};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return ~c;
  endfunction
`endif

  initial begin
    logic [7:0] up_q[$];
    logic [7:0] bus_exp[$];
    logic [7:0] crc_lo, crc_hi;
    int pops, aborts, dones;
    bit finished;
    vec_t e;
    crc_lo = 8'h00;
    crc_hi = 8'h00;
`ifdef ULPI_TX_CRC16_EN
    {crc_hi, crc_lo} = usb_crc2(8'h01, 8'h02);
`endif

    // name rst dir nxt val last d | data oe stp rdy done abt busy
    tbl.push_back(mk("rst_hold",      1,0,0,0,0,8'h00, 8'h00,0,0,0,0,0,0));
    tbl.push_back(mk("rst_rel_ta",    0,0,0,0,0,8'h00, 8'h00,0,0,0,0,0,0));
    tbl.push_back(mk("idle_noop",     0,0,0,0,0,8'h00, 8'h00,1,0,0,0,0,0));
    // handshake ACK
    tbl.push_back(mk("ack_txcmd",     0,0,0,1,1,8'hD2, 8'h42,1,0,0,0,0,0));
    tbl.push_back(mk("ack_wait1",     0,0,0,1,1,8'hD2, 8'h42,1,0,0,0,0,1));
    tbl.push_back(mk("ack_wait2",     0,0,0,1,1,8'hD2, 8'h42,1,0,0,0,0,1));
    tbl.push_back(mk("ack_pop",       0,0,1,1,1,8'hD2, 8'h42,1,0,1,0,0,1));
    tbl.push_back(mk("ack_stop",      0,0,0,0,0,8'h00, 8'h00,1,1,0,1,0,1));
    tbl.push_back(mk("ack_idle",      0,0,0,0,0,8'h00, 8'h00,1,0,0,0,0,0));
    // DATA0 packet, nxt 1-0-1
    tbl.push_back(mk("dat_txcmd",     0,0,0,1,0,8'hC3, 8'h43,1,0,0,0,0,0));
    tbl.push_back(mk("dat_pid",       0,0,1,1,0,8'hC3, 8'h43,1,0,1,0,0,1));
    tbl.push_back(mk("dat_b1_hold",   0,0,0,1,0,8'h01, 8'h01,1,0,0,0,0,1));
    tbl.push_back(mk("dat_b1_acc",    0,0,1,1,0,8'h01, 8'h01,1,0,1,0,0,1));
    tbl.push_back(mk("dat_b2_hold",   0,0,0,1,1,8'h02, 8'h02,1,0,0,0,0,1));
    tbl.push_back(mk("dat_b2_acc",    0,0,1,1,1,8'h02, 8'h02,1,0,1,0,0,1));
`ifdef ULPI_TX_CRC16_EN
    tbl.push_back(mk("dat_crc_lo",    0,0,1,0,0,8'h00, crc_lo,1,0,0,0,0,1));
    tbl.push_back(mk("dat_crc_hi",    0,0,1,0,0,8'h00, crc_hi,1,0,0,0,0,1));
`endif
    tbl.push_back(mk("dat_stop",      0,0,0,0,0,8'h00, 8'h00,1,1,0,1,0,1));
    tbl.push_back(mk("dat_idle",      0,0,0,0,0,8'h00, 8'h00,1,0,0,0,0,0));
    // dir preempts TX CMD
    tbl.push_back(mk("pre_txcmd",     0,0,0,1,1,8'hD2, 8'h42,1,0,0,0,0,0));
    tbl.push_back(mk("pre_dir_up",    0,1,0,1,1,8'hD2, 8'h00,0,0,0,0,0,1));
    tbl.push_back(mk("pre_dir_hi",    0,1,0,1,1,8'hD2, 8'h00,0,0,0,0,0,0));
    tbl.push_back(mk("pre_turnaround",0,0,0,1,1,8'hD2, 8'h00,0,0,0,0,0,0));
    tbl.push_back(mk("pre_retry",     0,0,0,1,1,8'hD2, 8'h42,1,0,0,0,0,0));
    tbl.push_back(mk("pre_pop",       0,0,1,1,1,8'hD2, 8'h42,1,0,1,0,0,1));
    tbl.push_back(mk("pre_stop",      0,0,0,0,0,8'h00, 8'h00,1,1,0,1,0,1));
    tbl.push_back(mk("pre_idle",      0,0,0,0,0,8'h00, 8'h00,1,0,0,0,0,0));
    // underrun
    tbl.push_back(mk("ur_txcmd",      0,0,0,1,0,8'hC3, 8'h43,1,0,0,0,0,0));
    tbl.push_back(mk("ur_pid",        0,0,1,1,0,8'hC3, 8'h43,1,0,1,0,0,1));
    tbl.push_back(mk("ur_starve",     0,0,1,0,0,8'h00, 8'h00,1,0,0,0,0,1));
    tbl.push_back(mk("ur_abort",      0,0,0,0,0,8'h00, 8'hFF,1,1,0,0,1,1));
    tbl.push_back(mk("ur_flush",      0,0,0,1,0,8'hAA, 8'h00,1,0,1,0,0,1));
    tbl.push_back(mk("ur_flush_last", 0,0,0,1,1,8'hBB, 8'h00,1,0,1,0,0,1));
    tbl.push_back(mk("ur_idle",       0,0,0,0,0,8'h00, 8'h00,1,0,0,0,0,0));
`ifdef ULPI_TX_CRC16_EN
    // zero-payload data packet gets CRC 0000
    tbl.push_back(mk("crc0_txcmd",    0,0,0,1,1,8'hC3, 8'h43,1,0,0,0,0,0));
    tbl.push_back(mk("crc0_pid",      0,0,1,1,1,8'hC3, 8'h43,1,0,1,0,0,1));
    tbl.push_back(mk("crc0_lo_hold",  0,0,0,0,0,8'h00, 8'h00,1,0,0,0,0,1));
    tbl.push_back(mk("crc0_lo",       0,0,1,0,0,8'h00, 8'h00,1,0,0,0,0,1));
    tbl.push_back(mk("crc0_hi",       0,0,1,0,0,8'h00, 8'h00,1,0,0,0,0,1));
    tbl.push_back(mk("crc0_stop",     0,0,0,0,0,8'h00, 8'h00,1,1,0,1,0,1));
    tbl.push_back(mk("crc0_idle",     0,0,0,0,0,8'h00, 8'h00,1,0,0,0,0,0));
`endif
    // reset while in STOP
    tbl.push_back(mk("rs_txcmd",      0,0,0,1,1,8'hD2, 8'h42,1,0,0,0,0,0));
    tbl.push_back(mk("rs_pop",        0,0,1,1,1,8'hD2, 8'h42,1,0,1,0,0,1));
    tbl.push_back(mk("rs_assert",     1,0,0,0,0,8'h00, 8'h00,0,0,0,0,0,0));
    tbl.push_back(mk("rs_release",    0,0,0,0,0,8'h00, 8'h00,0,0,0,0,0,0));
    tbl.push_back(mk("rs_idle",       0,0,0,0,0,8'h00, 8'h00,1,0,0,0,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      rst = tbl[i].rst; dir = tbl[i].dir; nxt = tbl[i].nxt;
      tx_valid = tbl[i].val; tx_last = tbl[i].last; tx_data = tbl[i].d;
      exp_q.push_back(tbl[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      chk(e.name,
          32'({ulpi_data_out, ulpi_oe, stp, tx_ready, tx_done, tx_abort, busy}),
          32'({e.e_data, e.e_oe, e.e_stp, e.e_rdy, e.e_done, e.e_abt, e.e_busy}));
    end

    // dir rises after one of four payload bytes; the rest must be flushed
    up_q    = '{8'hC3, 8'h11, 8'h22, 8'h33, 8'h44};
    bus_exp = '{8'h43, 8'h11};
    pops = 0; aborts = 0; dones = 0; finished = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk);
      #1;
      dir      = (cyc >= 3 && cyc <= 5);
      nxt      = (cyc == 1 || cyc == 2);
      tx_valid = (up_q.size() > 0);
      tx_data  = (up_q.size() > 0) ? up_q[0] : 8'h00;
      tx_last  = (up_q.size() == 1);
      @(negedge clk);
      if (cyc == 3) chk("mid_dir_abort_cycle", 32'({tx_abort, tx_ready, ulpi_oe}), 32'(3'b100));
      if (tx_abort) aborts++;
      if (tx_done) dones++;
      if (ulpi_oe && nxt && !stp) begin
        if (bus_exp.size() == 0) chk("mid_dir_extra_byte", 32'(ulpi_data_out), 32'h100);
        else chk("mid_dir_bus_byte", 32'(ulpi_data_out), 32'(bus_exp.pop_front()));
      end
      if (tx_ready) begin
        pops++;
        void'(up_q.pop_front());
      end
      if (cyc > 3 && up_q.size() == 0 && !busy) begin
        finished = 1'b1;
        break;
      end
    end
    chk("mid_dir_completed", 32'(finished), 32'd1);
    chk("mid_dir_pops", 32'(pops), 32'd5);
    chk("mid_dir_aborts", 32'(aborts), 32'd1);
    chk("mid_dir_dones", 32'(dones), 32'd0);
    chk("mid_dir_bus_left", 32'(bus_exp.size()), 32'd0);
    dir = 1'b0; nxt = 1'b0; tx_valid = 1'b0; tx_last = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
